usb_frame_fifo: RTL and testbench

// Downstream of the BLE packet analyzer. Consumes its USB-side byte stream (data/valid/frame)
// and stores whole frames in a byte FIFO. Frames become readable only once complete, so the
// USB host side never sees a partial frame. Frames that do not fit are dropped whole and counted.

---
 rtl/usb_frame_fifo.sv | 185 ++++++++++++++++++
 tb/tb_usb_frame_fifo.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : usb_frame_fifo
// Description : Whole-frame byte FIFO between the BLE packet analyzer and the
//               USB host side. Bytes of a frame are written speculatively and
//               become visible to the reader only after the frame completes.
//               A frame that does not fit is discarded in its entirety and
//               counted in a saturating drop counter.
// Ports       : clk_i       - system clock, rising edge
//               rst_i       - asynchronous reset, active-low
//               data_i      - byte from the packet analyzer
//               valid_i     - data_i valid (only honoured while frame_i=1)
//               frame_i     - high for the whole duration of one frame
//               data_o      - head byte of committed data (0 when empty)
//               last_o      - data_o is the final byte of its frame
//               valid_o     - committed byte available (first-word fall-through)
//               ready_i     - consumer pops data_o when valid_o & ready_i
//               level_o     - committed, unread entries
//               drop_cnt_o  - frames discarded, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module usb_frame_fifo #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [7:0]               data_i,
    input  logic                     valid_i,
    input  logic                     frame_i,
    output logic [7:0]               data_o,
    output logic                     last_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [CNT_W-1:0]         drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Storage entries are {last, byte}
    logic [8:0]       mem_q [DEPTH];

    state_t           state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;   // speculative write pointer
    logic [AW-1:0]    cmt_ptr_q, cmt_ptr_d; // end of committed data
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [7:0]       stg_q, stg_d;         // most recent accepted byte
    logic             stg_vld_q, stg_vld_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic             mem_we;
    logic [8:0]       mem_wdata;

    logic             accept;
    logic             full;
    logic             pop;
    logic [AW-1:0]    wr_inc;
    logic [AW-1:0]    level_raw;
    logic [8:0]       head;
    logic [CNT_W-1:0] drop_sat;

    assign accept    = frame_i & valid_i;
    assign wr_inc    = wr_ptr_q + 1'b1;
    // Uses the registered read pointer: a pop in the same cycle does not free space yet
    assign full      = (wr_inc == rd_ptr_q);
    assign valid_o   = (rd_ptr_q != cmt_ptr_q);
    assign pop       = valid_o & ready_i;
    assign head      = mem_q[rd_ptr_q];
    assign data_o    = valid_o ? head[7:0] : 8'h00;
    assign last_o    = valid_o ? head[8]   : 1'b0;
    assign level_raw = cmt_ptr_q - rd_ptr_q;
    assign level_o   = {1'b0, level_raw};
    assign drop_sat  = (&drop_q) ? drop_q : drop_q + 1'b1;
    assign drop_cnt_o = drop_q;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        cmt_ptr_d = cmt_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        stg_d     = stg_q;
        stg_vld_d = stg_vld_q;
        drop_d    = drop_q;
        mem_we    = 1'b0;
        mem_wdata = 9'h000;

        case (state_q)
            ST_IDLE: begin
                if (frame_i) begin
                    state_d = ST_RECV;
                    if (accept) begin
                        stg_d     = data_i;
                        stg_vld_d = 1'b1;
                    end
                end
            end

            ST_RECV: begin
                if (frame_i) begin
                    if (accept) begin
                        if (stg_vld_q) begin
                            // Staged byte is now known not to be the last one
                            if (full) begin
                                state_d   = ST_DROP;
                                stg_vld_d = 1'b0;
                            end else begin
                                mem_we    = 1'b1;
                                mem_wdata = {1'b0, stg_q};
                                wr_ptr_d  = wr_inc;
                                stg_d     = data_i;
                            end
                        end else begin
                            stg_d     = data_i;
                            stg_vld_d = 1'b1;
                        end
                    end
                end else begin
                    state_d   = ST_IDLE;
                    stg_vld_d = 1'b0;
                    // An empty frame leaves wr_ptr == cmt_ptr and commits nothing
                    if (stg_vld_q) begin
                        if (full) begin
                            wr_ptr_d = cmt_ptr_q;
                            drop_d   = drop_sat;
                        end else begin
                            mem_we    = 1'b1;
                            mem_wdata = {1'b1, stg_q};
                            wr_ptr_d  = wr_inc;
                            cmt_ptr_d = wr_inc;
                        end
                    end
                end
            end

            ST_DROP: begin
                if (!frame_i) begin
                    state_d   = ST_IDLE;
                    wr_ptr_d  = cmt_ptr_q;
                    stg_vld_d = 1'b0;
                    drop_d    = drop_sat;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            cmt_ptr_q <= '0;
            rd_ptr_q  <= '0;
            stg_q     <= 8'h00;
            stg_vld_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            cmt_ptr_q <= cmt_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            stg_q     <= stg_d;
            stg_vld_q <= stg_vld_d;
            drop_q    <= drop_d;
        end
    end

    // Array contents need no reset: outputs are gated by valid_o
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= mem_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_frame_fifo
// Description : Self-checking bench for usb_frame_fifo. Expected output bytes
//               are queued when frames are sent; a negedge monitor pops and
//               compares them whenever the DUT hands over a byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_frame_fifo;

    localparam int DEPTH = 8;
    localparam int CNT_W = 8;

    logic                   clk;
    logic                   rst_n;
    logic [7:0]             data_i;
    logic                   valid_i;
    logic                   frame_i;
    logic [7:0]             data_o;
    logic                   last_o;
    logic                   valid_o;
    logic                   ready_i;
    logic [$clog2(DEPTH):0] level_o;
    logic [CNT_W-1:0]       drop_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;
    logic [8:0] sb [$];

    usb_frame_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .frame_i    (frame_i),
        .data_o     (data_o),
        .last_o     (last_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .level_o    (level_o),
        .drop_cnt_o (drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every handshake must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL pop_unexpected: got 0x%0h expected no data", {last_o, data_o});
            end else begin
                chk("pop_data", int'({last_o, data_o}), int'(sb.pop_front()));
            end
        end
    end

    // Called and returns at posedge+1; leaves frame_i=0 for exactly one edge
    task automatic send_frame(input int n, input logic [7:0] base, input bit push);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b       = base + 8'h11 * i[7:0];
            frame_i = 1'b1;
            valid_i = 1'b1;
            data_i  = b;
            if (push) sb.push_back({(i == n - 1), b});
            @(posedge clk); #1;
        end
        frame_i = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'h00;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n   = 1'b0;
        frame_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        @(posedge clk); #1;
        ready_i = 1'b1;
        while (sb.size() != 0 && k < 40) begin
            @(posedge clk);
            k++;
        end
        #1 ready_i = 1'b0;
        chk({nm, "_left"}, sb.size(), 0);
        @(negedge clk);
        chk({nm, "_valid"}, int'(valid_o), 0);
        chk({nm, "_level"}, int'(level_o), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        frame_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_last",  int'(last_o), 0);
        chk("rst_data",  int'(data_o), 0);
        chk("rst_level", int'(level_o), 0);
        chk("rst_drop",  int'(drop_cnt_o), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: A1,B2,C3 with level tracking 3,2,1,0
        send_frame(3, 8'hA1, 1'b1);
        @(negedge clk);
        chk("t1_valid", int'(valid_o), 1);
        chk("t1_level3", int'(level_o), 3);
        @(posedge clk); #1 ready_i = 1'b1;
        for (int e = 3; e >= 1; e--) begin
            @(negedge clk);
            chk("t1_level", int'(level_o), e);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("t1_level0", int'(level_o), 0);
        chk("t1_empty", int'(valid_o), 0);
        chk("t1_last0", int'(last_o), 0);
        @(posedge clk); #1 ready_i = 1'b0;

        // 2: 5-byte frame fits, 4-byte frame overflows and is dropped
        do_reset();
        send_frame(5, 8'h10, 1'b1);
        send_frame(4, 8'h80, 1'b0);
        @(negedge clk);
        chk("t2_drop", int'(drop_cnt_o), 1);
        chk("t2_level", int'(level_o), 5);
        chk("t2_head", int'({last_o, data_o}), 9'h010);
        @(posedge clk); #1;
        drain("t2");

        // 3: back-to-back frames, consumer toggling ready
        do_reset();
        fork
            begin
                send_frame(2, 8'h11, 1'b1);
                send_frame(1, 8'h33, 1'b1);
            end
            begin
                repeat (12) begin
                    @(posedge clk); #1 ready_i = ~ready_i;
                end
            end
        join
        drain("t3");

        // 4: asynchronous reset mid-frame with committed data
        do_reset();
        send_frame(4, 8'h40, 1'b1);
        frame_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'hE1;
        @(posedge clk); #1 data_i = 8'hE2;
        @(posedge clk); #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("t4_valid", int'(valid_o), 0);
        chk("t4_level", int'(level_o), 0);
        frame_i = 1'b0;
        valid_i = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        send_frame(3, 8'h5A, 1'b1);
        @(negedge clk);
        chk("t4_level3", int'(level_o), 3);
        @(posedge clk); #1;
        drain("t4");

        // 5: frame without bytes, bytes without frame
        do_reset();
        frame_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 frame_i = 1'b0;
        @(posedge clk); #1;
        valid_i = 1'b1;
        data_i  = 8'h77;
        repeat (2) @(posedge clk);
        #1 valid_i = 1'b0;
        @(negedge clk);
        chk("t5_valid", int'(valid_o), 0);
        chk("t5_level", int'(level_o), 0);
        chk("t5_drop", int'(drop_cnt_o), 0);
        @(posedge clk); #1;

        // Boundary: DEPTH-1 bytes fit exactly
        send_frame(DEPTH - 1, 8'h01, 1'b1);
        @(negedge clk);
        chk("bnd_level", int'(level_o), DEPTH - 1);
        chk("bnd_drop", int'(drop_cnt_o), 0);
        @(posedge clk); #1;
        drain("bnd");

        // 6: oversize frames saturate the drop counter
        do_reset();
        for (int f = 0; f < 260; f++) begin
            send_frame(DEPTH + 1, 8'h00, 1'b0);
            if (f == 2) chk("t6_drop3", int'(drop_cnt_o), 3);
        end
        @(negedge clk);
        chk("t6_sat", int'(drop_cnt_o), 255);
        chk("t6_level", int'(level_o), 0);
        chk("t6_valid", int'(valid_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
